temporizador_bcd: RTL
=====================

Name: temporizador_bcd

Overview:
- Microwave countdown timer: accepts keypad digits, holds the cook time as three BCD digits (M:SS), and counts down once per prescaled tick while the door is closed.
- Sits directly upstream of the 7-segment decoder and drives its Minutos, DezenaSeg and Segundos inputs.
- Also produces the magnetron enable (Aquecendo), the end-of-cycle flag (Fim) and the current state.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per countdown second (minimum 2).
- CNT_W, 26, prescaler counter width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Key  in  4  keypad digit, BCD.
- KeyValid  in  1  one-cycle strobe; Key is valid in that cycle.
- Start  in  1  one-cycle strobe.
- Stop  in  1  one-cycle strobe (pause/cancel).
- DoorClosed  in  1  level; 1 = door closed.
- Minutos  out  4  minutes digit, 0-9.
- DezenaSeg  out  4  tens-of-seconds digit, 0-5.
- Segundos  out  4  seconds digit, 0-9.
- Aquecendo  out  1  magnetron enable.
- Fim  out  1  cycle-complete flag.
- Estado  out  2  state: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE.

Behaviour:
- Reset (rst_n=0, asynchronous): all digits 0, prescaler 0, state IDLE, Fim=0.
- Aquecendo = (Estado==RUN) & DoorClosed, combinational, so it drops in the same cycle the door opens.
- Event priority within one cycle: door open > Stop > Start > KeyValid.
- IDLE, KeyValid with Key<=9:
  - Shift left: Minutos<=DezenaSeg, DezenaSeg<=Segundos, Segundos<=Key. The old Minutos digit is discarded.
  - If current Segundos>5, the key is rejected (digits unchanged), since DezenaSeg may never exceed 5.
  - Key>9 is always ignored.
- IDLE, Start:
  - Time nonzero and DoorClosed=1: go to RUN, prescaler cleared.
  - Time 0:00: see Optional Feature.
  - DoorClosed=0: Start ignored.
- IDLE, Stop: digits cleared to 0:00.
- RUN, prescaler:
  - Increments every cycle; at TICK_DIV-1 it wraps to 0 and the time decrements on that same edge.
  - First decrement occurs TICK_DIV cycles after the Start edge.
- RUN, BCD decrement with borrow:
  - Segundos 0 -> 9 with borrow to DezenaSeg.
  - DezenaSeg 0 -> 5 with borrow to Minutos.
  - Minutos decrements on borrow.
  - A decrement that yields 0:00 moves to DONE on the same edge and sets Fim=1.
- RUN, exits:
  - DoorClosed=0 or Stop: go to PAUSE, digits frozen, prescaler held.
  - Door-open and tick in the same cycle: door wins, no decrement.
- PAUSE:
  - Start with DoorClosed=1: go to RUN, prescaler cleared.
  - Stop: go to IDLE, digits cleared to 0:00.
  - KeyValid: ignored.
- DONE:
  - Digits stay 0:00, Fim=1.
  - Stop, KeyValid, or DoorClosed falling to 0: go to IDLE, Fim=0. That KeyValid is consumed and does not enter a digit.
- Start in RUN, Stop in IDLE at 0:00, and KeyValid outside IDLE have no effect.
- Digits never leave valid BCD ranges (Minutos 0-9, DezenaSeg 0-5, Segundos 0-9). Maximum time 9:59.

Optional Feature:
- Macro: TEMPORIZADOR_QUICK_START_EN.
- Defined: Start in IDLE at 0:00 with DoorClosed=1 loads 0:30 and enters RUN in the same edge.
- Undefined: Start at 0:00 is ignored and the state stays IDLE.

Test Plan:
- Reset: assert rst_n=0 mid-RUN at 1:23 -> asynchronously Minutos/DezenaSeg/Segundos = 0/0/0, Estado=0, Fim=0, Aquecendo=0.
- Entry/borrow (TICK_DIV=4):
  - Keys 1,3,0 -> 1:30; Start with door closed -> Aquecendo=1.
  - After 4 cycles -> 1:29.
  - Continue to 1:00, next tick -> 0:59.
- Key rejection: keys 1,6 -> 0:16; key 7 -> still 0:16; key 12 -> still 0:16.
- Completion: load 0:02, Start -> 0:01 after 4 cycles, 0:00 after 8 cycles with Estado=3, Fim=1, Aquecendo=0 on the same edge; Stop -> Estado=0, Fim=0.
- Door interlock:
  - RUN at 0:45, drop DoorClosed -> Aquecendo=0 in the same cycle, Estado=2, digits frozen across 20 cycles.
  - Close door and Start -> RUN; 0:44 arrives 4 cycles later.
  - Start with door open in PAUSE -> stays PAUSE.
- Quick start: Start at 0:00 -> with macro defined, 0:30 and Estado=1; without it, stays 0:00, Estado=0.

Source files
------------

// File: rtl/temporizador_bcd.sv
// -----------------------------------------------------------------------------
// temporizador_bcd
//
// Microwave countdown timer. Keypad digits are shifted into a three-digit BCD
// cook time (M:SS). While running with the door closed, the time counts down
// once per prescaled tick. The time digits drive the 7-segment decoder
// directly.
//
// Optional feature (macro TEMPORIZADOR_QUICK_START_EN):
//   defined   - Start in IDLE at 0:00 with the door closed loads 0:30 and runs.
//   undefined - Start at 0:00 is ignored.
//
// Parameters:
//   TICK_DIV   clk cycles per countdown second (>= 2)
//   CNT_W      prescaler width, 2**CNT_W >= TICK_DIV
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   Key         keypad digit (BCD), sampled when KeyValid=1
//   KeyValid    one-cycle key strobe
//   Start       one-cycle start strobe
//   Stop        one-cycle pause/cancel strobe
//   DoorClosed  door level, 1 = closed
//   Minutos     minutes digit 0-9
//   DezenaSeg   tens-of-seconds digit 0-5
//   Segundos    seconds digit 0-9
//   Aquecendo   magnetron enable (RUN and door closed, combinational)
//   Fim         cycle-complete flag (high in DONE)
//   Estado      0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
// -----------------------------------------------------------------------------
module temporizador_bcd #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Key,
  input  logic       KeyValid,
  input  logic       Start,
  input  logic       Stop,
  input  logic       DoorClosed,
  output logic [3:0] Minutos,
  output logic [3:0] DezenaSeg,
  output logic [3:0] Segundos,
  output logic       Aquecendo,
  output logic       Fim,
  output logic [1:0] Estado
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       min_q, min_d;
  logic [3:0]       dez_q, dez_d;
  logic [3:0]       seg_q, seg_d;
  logic [CNT_W-1:0] presc_q, presc_d;

  logic [3:0] dec_min, dec_dez, dec_seg;
  logic       dec_zero;
  logic       time_zero;
  logic       key_ok;
  logic       tick;

  assign time_zero = (min_q == 4'd0) && (dez_q == 4'd0) && (seg_q == 4'd0);
  assign tick      = (presc_q == TICK_LAST);

  // A key is accepted only if it is a decimal digit and the digit it pushes
  // into the tens-of-seconds position is still a legal 0-5 value.
  assign key_ok = KeyValid && (Key <= 4'd9) && (seg_q <= 4'd5);

  // BCD decrement with borrow. Only used in RUN, where the time is nonzero,
  // so the minutes digit can never underflow.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    dec_min = min_q;
    dec_dez = dez_q;
    dec_seg = seg_q;
    if (seg_q != 4'd0) begin
      dec_seg = seg_q - 4'd1;
    end else begin
      dec_seg = 4'd9;
      if (dez_q != 4'd0) begin
        dec_dez = dez_q - 4'd1;
      end else begin
        dec_dez = 4'd5;
        dec_min = min_q - 4'd1;
      end
    end
  end

  assign dec_zero = (dec_min == 4'd0) && (dec_dez == 4'd0) && (dec_seg == 4'd0);

  // Next-state logic. Within a state, events are tested in priority order:
  // door open, Stop, Start, KeyValid.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    dez_d   = dez_q;
    seg_d   = seg_q;
    presc_d = presc_q;

    case (state_q)
      S_IDLE: begin
        if (Stop) begin
          min_d = 4'd0;
          dez_d = 4'd0;
          seg_d = 4'd0;
        end else if (Start) begin
          // With the door open, Start is simply dropped.
          if (DoorClosed) begin
            if (!time_zero) begin
              state_d = S_RUN;
              presc_d = '0;
            end
`ifdef TEMPORIZADOR_QUICK_START_EN
            else begin
              min_d   = 4'd0;
              dez_d   = 4'd3;
              seg_d   = 4'd0;
              state_d = S_RUN;
              presc_d = '0;
            end
`endif
          end
        end else if (key_ok) begin
          min_d = dez_q;
          dez_d = seg_q;
          seg_d = Key;
        end
      end

      S_RUN: begin
        // Door opening beats a coincident tick: no decrement, prescaler held.
        if (!DoorClosed || Stop) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          presc_d = '0;
          min_d   = dec_min;
          dez_d   = dec_dez;
          seg_d   = dec_seg;
          if (dec_zero) begin
            state_d = S_DONE;
          end
        end else begin
          presc_d = presc_q + CNT_W'(1);
        end
      end

      S_PAUSE: begin
        if (Stop) begin
          state_d = S_IDLE;
          min_d   = 4'd0;
          dez_d   = 4'd0;
          seg_d   = 4'd0;
        end else if (Start && DoorClosed) begin
          state_d = S_RUN;
          presc_d = '0;
        end
      end

      S_DONE: begin
        // The KeyValid that acknowledges completion is consumed here and
        // never reaches the digit shifter.
        if (!DoorClosed || Stop || KeyValid) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: every register here, prescaler included, has a defined reset value
  // so the display and the FSM come up in a known state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      min_q   <= 4'd0;
      dez_q   <= 4'd0;
      seg_q   <= 4'd0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      dez_q   <= dez_d;
      seg_q   <= seg_d;
      presc_q <= presc_d;
    end
  end

  assign Minutos   = min_q;
  assign DezenaSeg = dez_q;
  assign Segundos  = seg_q;
  assign Estado    = state_q;
  assign Fim       = (state_q == S_DONE);
  // Combinational so the magnetron drops in the very cycle the door opens.
  assign Aquecendo = (state_q == S_RUN) && DoorClosed;

endmodule
